// File: rtl/load_canvas_if.sv
// Bus bundle between load_canvas and its row memory / pixel writer.
// master: the load_canvas side (drives the row read and the pixel writes).
// slave:  the memory + pixel writer side.
interface load_canvas_if #(
    parameter int WIDTH = 640
);
    logic [8:0]       read_addr;
    logic             rd_en;
    logic [WIDTH-1:0] read_data;
    logic [10:0]      pix_x;
    logic [10:0]      pix_y;
    logic             pix_color;
    logic             pix_valid;
    logic             pix_ready;

    modport master (
        output read_addr, rd_en, pix_x, pix_y, pix_color, pix_valid,
        input  read_data, pix_ready
    );

    modport slave (
        input  read_addr, rd_en, pix_x, pix_y, pix_color, pix_valid,
        output read_data, pix_ready
    );
endinterface

// File: rtl/load_canvas.sv
// load_canvas: replays a saved 1-bpp canvas from row memory as pixel writes.
// Each row is fetched as one WIDTH-bit word, then emitted pixel by pixel
// (x = bit index, y = row) over a valid/ready handshake.
// Optional build macro SKIP_ZERO_ROW_EN: rows that read back as all zeros
// are not emitted (the destination is assumed to be pre-cleared).
module load_canvas #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int RD_LATENCY = 1
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    input  logic           load_sw,
    output logic           busy,
    output logic           done,
    load_canvas_if.master  bus
);
    localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_COL  = CW'(WIDTH - 1);
    localparam logic [8:0]     LAST_ROW  = 9'(HEIGHT - 1);
    localparam logic [2:0]     LAST_WAIT = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             load_sw_q;
    logic             armed_q;
    logic [8:0]       row_q;
    logic [CW-1:0]    col_q;
    logic [2:0]       wait_q;
    logic [WIDTH-1:0] rowreg_q;
    logic [8:0]       read_addr_q;
    logic             rd_en_q;
    logic [10:0]      pix_x_q;
    logic [10:0]      pix_y_q;
    logic             pix_color_q;
    logic             pix_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             start_d;
    logic             accept_d;
    logic             skip_row_d;
    logic [CW-1:0]    col_d;

    // armed_q blocks a level that was already high when reset released
    assign start_d  = load_sw & ~load_sw_q & armed_q;
    assign accept_d = pix_valid_q & bus.pix_ready;
    assign col_d    = col_q + CW'(1);

`ifdef SKIP_ZERO_ROW_EN
    assign skip_row_d = (bus.read_data == '0);
`else
    assign skip_row_d = 1'b0;
`endif

    assign bus.read_addr = read_addr_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_color = pix_color_q;
    assign bus.pix_valid = pix_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Load switch edge register; arms start detection one cycle after reset
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            load_sw_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            load_sw_q <= load_sw;
            armed_q   <= 1'b1;
        end
    end

    // Control FSM with registered outputs: fetch row, wait, emit pixels, advance
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            wait_q      <= '0;
            rowreg_q    <= '0;
            read_addr_q <= '0;
            rd_en_q     <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= 1'b0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        row_q       <= '0;
                        read_addr_q <= '0;
                        rd_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == LAST_WAIT) begin
                        // the only cycle in which read_data is trusted
                        rowreg_q <= bus.read_data;
                        col_q    <= '0;
                        if (skip_row_d) begin
                            state_q <= S_NEXT;
                        end else begin
                            pix_valid_q <= 1'b1;
                            pix_x_q     <= '0;
                            pix_y_q     <= 11'(row_q);
                            pix_color_q <= bus.read_data[0];
                            state_q     <= S_EMIT;
                        end
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                S_EMIT: begin
                    if (accept_d) begin
                        if (col_q == LAST_COL) begin
                            pix_valid_q <= 1'b0;
                            state_q     <= S_NEXT;
                        end else begin
                            col_q       <= col_d;
                            pix_x_q     <= 11'(col_d);
                            pix_color_q <= rowreg_q[col_d];
                        end
                    end
                end
                S_NEXT: begin
                    if (row_q == LAST_ROW) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        row_q       <= row_q + 9'd1;
                        read_addr_q <= row_q + 9'd1;
                        rd_en_q     <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_canvas.sv
// Bench for load_canvas on a reduced 64x12 canvas with a 2-cycle memory.
// A queue of expected pixels is built directly from the memory image; every
// cycle with pix_valid is compared against the queue head.
module tb_load_canvas;
    localparam int W = 64;
    localparam int H = 12;
    localparam int L = 2;

    logic clk;
    logic reset_n;
    logic load_sw;
    logic busy;
    logic done;

    load_canvas_if #(.WIDTH(W)) bus ();

    load_canvas #(.WIDTH(W), .HEIGHT(H), .RD_LATENCY(L)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .load_sw  (load_sw),
        .busy     (busy),
        .done     (done),
        .bus      (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model: data only valid in the cycle it is due
    logic [W-1:0] mem [0:511];
    logic [L:1]   vld_p;
    logic [8:0]   adr_p [1:L];
    logic [W-1:0] garb;
    assign garb = {(W/8){8'h6c}};

    always @(posedge clk) begin
        vld_p[1] <= bus.rd_en;
        adr_p[1] <= bus.read_addr;
        for (int i = 2; i <= L; i++) begin
            vld_p[i] <= vld_p[i-1];
            adr_p[i] <= adr_p[i-1];
        end
    end
    assign bus.read_data = vld_p[L] ? mem[adr_p[L]] : garb;

    // ---------------- scoreboard
    typedef struct {
        int x;
        int y;
        bit c;
    } pix_t;
    pix_t exp_q[$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    task automatic build_model();
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
`ifdef SKIP_ZERO_ROW_EN
            if (mem[y] == '0) continue;
`endif
            for (int x = 0; x < W; x++) exp_q.push_back('{x, y, mem[y][x]});
        end
    endtask

    int  pix_acc, done_cnt, ones5, sumx5, hold102, row7_cnt, not7_cnt;
    int  last_x, last_y, last_end_cyc, start_cyc;
    bit  first_pending, row_gap_pending, prev_acc_mid, prev_done;

    // compare process: every cycle the outputs are meaningful
    always @(negedge clk) begin
        if (!reset_n) begin
            first_pending   = 0;
            row_gap_pending = 0;
            prev_acc_mid    = 0;
            prev_done       = 0;
        end else begin
            if (prev_acc_mid) chk("b2b_valid", 64'(bus.pix_valid), 64'd1);
            prev_acc_mid = 0;
            if (bus.pix_valid) begin
                chk("pix_expected", 64'(exp_q.size() != 0), 64'd1);
                chk("busy_with_pix", 64'(busy), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("pix_x", 64'(bus.pix_x), 64'(exp_q[0].x));
                    chk("pix_y", 64'(bus.pix_y), 64'(exp_q[0].y));
                    chk("pix_color", 64'(bus.pix_color), 64'(exp_q[0].c));
                    if (first_pending && exp_q[0].x == 0 && exp_q[0].y == 0)
                        chk("first_latency", 64'(cyc - start_cyc), 64'(2 + L));
                    if (row_gap_pending && exp_q[0].x == 0 && exp_q[0].y == last_y + 1)
                        chk("row_gap", 64'(cyc - last_end_cyc), 64'(3 + L));
                    first_pending   = 0;
                    row_gap_pending = 0;
                    if (bus.pix_x == 11'd10 && bus.pix_y == 11'd2) hold102++;
                    if (bus.pix_ready) begin
                        pix_acc++;
                        last_x = exp_q[0].x;
                        last_y = exp_q[0].y;
                        if (last_y == 5 && exp_q[0].c) begin
                            ones5++;
                            sumx5 += last_x;
                        end
                        if (last_y == 7) row7_cnt++;
                        else not7_cnt++;
                        if (last_x == W - 1) begin
                            row_gap_pending = 1;
                            last_end_cyc    = cyc;
                        end else begin
                            prev_acc_mid = 1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
            if (done) begin
                chk("done_after_last", 64'(exp_q.size()), 64'd0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    // ---------------- pix_ready driver
    int mode  = 0;
    int stall = 0;
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: bus.pix_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.pix_valid && bus.pix_x == 11'd10 && bus.pix_y == 11'd2 && stall < 4) begin
                        bus.pix_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.pix_ready = 1'b1;
                    end
                end
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string name);
        chk(name, 64'({bus.read_addr, bus.rd_en, bus.pix_x, bus.pix_y,
                       bus.pix_color, bus.pix_valid, busy, done}), 64'd0);
    endtask

    int done_base;
    task automatic start_load();
        build_model();
        pix_acc = 0; ones5 = 0; sumx5 = 0; hold102 = 0; stall = 0;
        row7_cnt = 0; not7_cnt = 0;
        done_base = done_cnt;
        load_sw = 1'b0;
        tick(1);
        load_sw       = 1'b1;
        start_cyc     = cyc;
        first_pending = 1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_in_budget", 64'(done_cnt != done_base), 64'd1);
        tick(2);
    endtask

    task automatic wait_pix(input int x, input int y, input string name);
        int n = 0;
        while (!(bus.pix_valid && bus.pix_y == 11'(y) && (x < 0 || bus.pix_x == 11'(x))) && n < 5000) begin
            tick(1);
            n++;
        end
        chk(name, 64'(bus.pix_valid && bus.pix_y == 11'(y)), 64'd1);
    endtask

    // ---------------- directed tests
    initial begin
        int dsave;
        reset_n  = 1'b0;
        load_sw  = 1'b1;
        done_cnt = 0;
        for (int r = 0; r < 512; r++) mem[r] = '0;
        tick(3);
        check_outs_zero("reset_outputs");
        reset_n = 1'b1;
        tick(20);
        chk("held_sw_no_start", 64'(busy), 64'd0);

        // 1: alternating rows of zeros / ones
        for (int r = 0; r < H; r++) mem[r] = {W{r[0]}};
        start_load();
        wait_done(5000);
        chk("t1_pixels", 64'(pix_acc), 64'd768);
        chk("t1_last_x", 64'(last_x), 64'd63);
        chk("t1_last_y", 64'(last_y), 64'd11);
        chk("t1_dones", 64'(done_cnt - done_base), 64'd1);
        $display("load 1: pixels=%0d dones=%0d", pix_acc, done_cnt - done_base);

        // 2: row 5 has only bits 3 and W-1 set
        for (int r = 0; r < H; r++) mem[r] = {(W/8){8'(r * 37 + 11)}};
        mem[5] = '0;
        mem[5][3] = 1'b1;
        mem[5][W-1] = 1'b1;
        start_load();
        wait_done(5000);
        chk("t2_row5_ones", 64'(ones5), 64'd2);
        chk("t2_row5_sumx", 64'(sumx5), 64'd66);
        chk("t2_pixels", 64'(pix_acc), 64'd768);
        $display("load 2: pixels=%0d row5_ones=%0d", pix_acc, ones5);

        // 3: 4-cycle stall on (10,2)
        for (int r = 0; r < H; r++) mem[r] = {W{r[0]}};
        mode = 2;
        start_load();
        wait_done(5000);
        chk("t3_hold_cycles", 64'(hold102), 64'd5);
        chk("t3_pixels", 64'(pix_acc), 64'd768);
        $display("load 3: pixels=%0d hold=%0d", pix_acc, hold102);

        // 4: second edge during row 6 is ignored; random ready
        mode = 1;
        start_load();
        wait_pix(-1, 6, "t4_reach_row6");
        load_sw = 1'b0;
        tick(1);
        load_sw = 1'b1;
        wait_done(8000);
        dsave = done_cnt;
        tick(30);
        chk("t4_dones", 64'(done_cnt - done_base), 64'd1);
        chk("t4_no_restart", 64'(busy), 64'd0);
        chk("t4_pixels", 64'(pix_acc), 64'd768);
        $display("load 4: pixels=%0d dones=%0d", pix_acc, done_cnt - done_base);

        // 5: async reset mid-load at (30,8), then a clean restart
        mode = 0;
        start_load();
        wait_pix(30, 8, "t5_reach_30_8");
        dsave = done_cnt;
        #1;
        reset_n = 1'b0;
        #1;
        check_outs_zero("t5_async_reset_outputs");
        exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("t5_no_done_on_reset", 64'(done_cnt), 64'(dsave));
        start_load();
        wait_done(5000);
        chk("t5_restart_pixels", 64'(pix_acc), 64'd768);
        $display("load 5: pixels=%0d after reset", pix_acc);

        // 6: only row 7 non-zero
        for (int r = 0; r < H; r++) mem[r] = '0;
        mem[7] = '1;
        start_load();
        wait_done(5000);
        chk("t6_row7_pixels", 64'(row7_cnt), 64'd64);
`ifdef SKIP_ZERO_ROW_EN
        chk("t6_pixels", 64'(pix_acc), 64'd64);
        chk("t6_other_rows", 64'(not7_cnt), 64'd0);
`else
        chk("t6_pixels", 64'(pix_acc), 64'd768);
`endif
        chk("t6_dones", 64'(done_cnt - done_base), 64'd1);
        $display("load 6: pixels=%0d row7=%0d", pix_acc, row7_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
